// File: rtl/rmm_arb_pkg.sv
// Shared definitions for the rmm_arbiter RAM-sharing controller.
// Holds the FSM state encoding, the RAM word width derivation and the
// even-parity helper used when RMM_ARBITER_PARITY_EN is defined.
package rmm_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Widest payload the parity helper accepts; narrower data is zero-extended.
    localparam int unsigned PAR_MAX_W = 64;

    // RAM word width: one extra parity bit when the parity option is built in.
    function automatic int unsigned mem_w(input int unsigned w);
`ifdef RMM_ARBITER_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

    // Even parity: the returned bit makes the XOR of data plus parity zero.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rmm_rr_pick.sv
// Two-way round-robin picker.
// Ports:
//   req0, req1 : pending requests
//   last       : requester granted most recently
//   valid      : at least one request pending
//   winner     : selected requester (0/1); meaningful only when valid
module rmm_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    assign valid = req0 | req1;

    // A lone requester wins outright; on a tie the one not served last wins.
    assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/rmm_arbiter.sv
// Two-port controller sharing one single-port RAM (2**N x MEM_W) between
// two requesters. Round-robin arbitration in IDLE, one-cycle RAM access in
// ACCESS, read data returned one edge after the grant.
// The RAM writes and updates data_out on the falling clock edge.
// Optional build macro: RMM_ARBITER_PARITY_EN adds an even-parity bit to
// each stored word and flags a parity error on read completion.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   req/we/addr/wdata 0,1           : requester commands (req held until gnt)
//   gnt 0,1                         : one-cycle command-accepted pulse
//   rvalid/rdata 0,1                : read completion pulse and held data
//   mem_addr/mem_rw/mem_din         : RAM control to the RAM instance
//   mem_dout                        : RAM read-out
//   perr                            : parity error pulse (0 without option)
module rmm_arbiter
    import rmm_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned MEM_W = mem_w(W)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0,
    input  logic             we0,
    input  logic [N-1:0]     addr0,
    input  logic [W-1:0]     wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [W-1:0]     rdata0,

    input  logic             req1,
    input  logic             we1,
    input  logic [N-1:0]     addr1,
    input  logic [W-1:0]     wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [W-1:0]     rdata1,

    output logic [N-1:0]     mem_addr,
    output logic             mem_rw,
    output logic [MEM_W-1:0] mem_din,
    input  logic [MEM_W-1:0] mem_dout,

    output logic             perr
);

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   cmd_id_q, cmd_id_d;

    logic             gnt0_d, gnt1_d;
    logic             rvalid0_d, rvalid1_d;
    logic [W-1:0]     rdata0_d, rdata1_d;
    logic [N-1:0]     mem_addr_d;
    logic             mem_rw_d;
    logic [MEM_W-1:0] mem_din_d;

    logic             pick_valid;
    logic             pick_winner;

    logic             sel_we;
    logic [N-1:0]     sel_addr;
    logic [W-1:0]     sel_wdata;
    logic [MEM_W-1:0] sel_word;

    rmm_rr_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Command of the current round-robin winner.
    assign sel_we    = pick_winner ? we1    : we0;
    assign sel_addr  = pick_winner ? addr1  : addr0;
    assign sel_wdata = pick_winner ? wdata1 : wdata0;

`ifdef RMM_ARBITER_PARITY_EN
    logic perr_d;
    assign sel_word = {even_parity(PAR_MAX_W'(sel_wdata)), sel_wdata};
`else
    assign sel_word = MEM_W'(sel_wdata);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cmd_id_d   = cmd_id_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0;
        rdata1_d   = rdata1;
        mem_addr_d = mem_addr;
        mem_rw_d   = 1'b0;
        mem_din_d  = mem_din;
`ifdef RMM_ARBITER_PARITY_EN
        perr_d     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = ACCESS;
                    last_d     = pick_winner;
                    cmd_id_d   = pick_winner;
                    gnt0_d     = ~pick_winner;
                    gnt1_d     = pick_winner;
                    mem_addr_d = sel_addr;
                    mem_rw_d   = sel_we;
                    mem_din_d  = sel_word;
                end
            end

            ACCESS: begin
                state_d = IDLE;
                // mem_rw still holds the command direction during ACCESS.
                if (!mem_rw) begin
                    if (cmd_id_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = mem_dout[W-1:0];
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = mem_dout[W-1:0];
                    end
`ifdef RMM_ARBITER_PARITY_EN
                    perr_d = ^mem_dout;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cmd_id_q <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            mem_addr <= '0;
            mem_rw   <= 1'b0;
            mem_din  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cmd_id_q <= cmd_id_d;
            gnt0     <= gnt0_d;
            gnt1     <= gnt1_d;
            rvalid0  <= rvalid0_d;
            rvalid1  <= rvalid1_d;
            rdata0   <= rdata0_d;
            rdata1   <= rdata1_d;
            mem_addr <= mem_addr_d;
            mem_rw   <= mem_rw_d;
            mem_din  <= mem_din_d;
        end
    end

`ifdef RMM_ARBITER_PARITY_EN
    // Parity error flag, pulsed alongside rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr <= 1'b0;
        end else begin
            perr <= perr_d;
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule
